// File: rtl/instruction_fetch.sv
`default_nettype none
//==============================================================================
// Module   : instruction_fetch
// Purpose  : Instruction fetch stage. Issues single-outstanding requests to an
//            instruction memory, tracks redirects from decode, buffers a
//            returning word while decode is stalled, and drives the IF/ID
//            pipeline register (inst / pc / inst_valid).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   asynchronous reset, active-high
//   clk_en       in   1   pipeline advance (0 = stall, IF/ID holds)
//   branch_taken in   1   redirect request from decode
//   jump_addr    in  32   redirect target from decode
//   imem_req     out  1   single-cycle fetch request strobe
//   imem_addr    out 32   fetch address, valid while imem_req = 1
//   imem_rvalid  in   1   response strobe
//   imem_rdata   in  32   instruction word, valid with imem_rvalid
//   inst         out 32   registered instruction to decode
//   pc           out 32   registered PC of inst
//   inst_valid   out  1   1 = fetched instruction, 0 = bubble
//==============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        branch_taken,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid
);

    // Fetch FSM encoding
    localparam logic [1:0] ST_REQ     = 2'd0; // issue a request this cycle
    localparam logic [1:0] ST_WAIT    = 2'd1; // response pending
    localparam logic [1:0] ST_DISCARD = 2'd2; // pending response must be dropped
    localparam logic [1:0] ST_HOLD    = 2'd3; // word buffered, decode stalled

    // Fetch addresses are always word aligned, including the reset vector.
    localparam logic [31:0] C_RESET_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] C_PC_STEP  = 32'd4;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_pc_fetch;   // address of the current / next fetch
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_inst_valid;
    logic [31:0] r_hold_inst;  // word captured while decode was stalled
    logic [31:0] r_hold_pc;    // PC of the captured word

    //--------------------------------------------------------------------------
    // Combinational next-state signals
    //--------------------------------------------------------------------------
    logic [1:0]  w_state_nxt;
    logic [31:0] w_pc_fetch_nxt;
    logic        w_ifid_load;
    logic [31:0] w_ifid_inst;
    logic [31:0] w_ifid_pc;
    logic        w_ifid_valid;
    logic        w_hold_load;

    logic        w_redirect;
    logic [31:0] w_jump_aligned;
    logic [31:0] w_fetch_addr;
    logic        w_unused_jump_lsbs;

    // A redirect only counts when the pipeline advances; a stalled decode may
    // still be presenting a stale branch decision.
    assign w_redirect     = branch_taken & clk_en;
    assign w_jump_aligned = {jump_addr[31:2], 2'b00};

    // The two low target bits carry no information for word fetches.
    assign w_unused_jump_lsbs = &{1'b0, jump_addr[1:0]};

    // In REQ a same-cycle redirect goes straight to the bus so no cycle is
    // wasted fetching down the wrong path.
    assign w_fetch_addr = ((r_state == ST_REQ) && w_redirect) ? w_jump_aligned
                                                              : r_pc_fetch;

    // Request is masked while reset is asserted so nothing escapes on the
    // bus before the first post-reset edge.
    assign imem_req  = (r_state == ST_REQ) & ~rst;
    assign imem_addr = w_fetch_addr;

    assign inst       = r_inst;
    assign pc         = r_pc;
    assign inst_valid = r_inst_valid;

    //--------------------------------------------------------------------------
    // Next-state / datapath control
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_fetch_nxt = r_pc_fetch;
        w_ifid_load    = 1'b0;
        w_ifid_inst    = NOP_INST;
        w_ifid_pc      = 32'd0;
        w_ifid_valid   = 1'b0;
        w_hold_load    = 1'b0;

        case (r_state)
            ST_REQ: begin
                // Request goes out regardless of clk_en; only one can be in
                // flight, and this is the only state that launches one.
                // Any response seen here is stale and is ignored.
                w_pc_fetch_nxt = w_fetch_addr;
                w_state_nxt    = ST_WAIT;
                w_ifid_load    = clk_en;
            end

            ST_WAIT: begin
                if (w_redirect) begin
                    // The in-flight word is on the wrong path. If it arrives
                    // this very cycle it is simply dropped; otherwise it must
                    // be drained before the next request can go out.
                    w_pc_fetch_nxt = w_jump_aligned;
                    w_ifid_load    = 1'b1;
                    w_state_nxt    = imem_rvalid ? ST_REQ : ST_DISCARD;
                end else if (imem_rvalid) begin
                    if (clk_en) begin
                        w_ifid_load    = 1'b1;
                        w_ifid_inst    = imem_rdata;
                        w_ifid_pc      = r_pc_fetch;
                        w_ifid_valid   = 1'b1;
                        w_pc_fetch_nxt = r_pc_fetch + C_PC_STEP;
                        w_state_nxt    = ST_REQ;
                    end else begin
                        // Decode is stalled: park the word until it advances.
                        w_hold_load = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_ifid_load = clk_en;
                end
            end

            ST_DISCARD: begin
                w_ifid_load = clk_en;
                if (w_redirect) begin
                    w_pc_fetch_nxt = w_jump_aligned;
                end
                if (imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_fetch_nxt = w_jump_aligned;
                    w_ifid_load    = 1'b1;
                    w_state_nxt    = ST_REQ;
                end else if (clk_en) begin
                    w_ifid_load    = 1'b1;
                    w_ifid_inst    = r_hold_inst;
                    w_ifid_pc      = r_hold_pc;
                    w_ifid_valid   = 1'b1;
                    w_pc_fetch_nxt = r_hold_pc + C_PC_STEP;
                    w_state_nxt    = ST_REQ;
                end
            end

            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Fetch state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_REQ;
            r_pc_fetch <= C_RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_pc_fetch <= w_pc_fetch_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // IF/ID pipeline register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst       <= NOP_INST;
            r_pc         <= 32'd0;
            r_inst_valid <= 1'b0;
        end else if (w_ifid_load) begin
            r_inst       <= w_ifid_inst;
            r_pc         <= w_ifid_pc;
            r_inst_valid <= w_ifid_valid;
        end
    end

    //--------------------------------------------------------------------------
    // Stall hold buffer
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_inst <= 32'd0;
            r_hold_pc   <= 32'd0;
        end else if (w_hold_load) begin
            r_hold_inst <= imem_rdata;
            r_hold_pc   <= r_pc_fetch;
        end
    end

endmodule
`default_nettype wire
